mux_arb_n: RTL and testbench
============================

# mux_arb_n

Parametrised N-channel, W-bit selector with a registered output stage and valid/ready handshaking on every channel. It generalises the fixed 4:1 32-bit datapath mux into a buffered, flow-controlled multiplexer. Selection is either directed by an external select code or made by an internal round-robin arbiter. It sits between multiple producers (forwarding sources, memory-response or bus-master ports) and a single downstream pipeline consumer.

## Interface
- WIDTH, 32, data width per channel
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), localparam width of select/channel codes
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = directed (use sel), 1 = round-robin
- sel  input  SEL_W  channel code in directed mode
- in_valid  input  CHANNELS  per-channel valid
- in_last  input  CHANNELS  per-channel end-of-burst marker (used only under MUX_ARB_LOCK_EN)
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  one-hot or zero; channel i accepted when in_valid[i] & in_ready[i]
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts when out_valid & out_ready
- out_data  output  WIDTH  registered data
- out_chan  output  SEL_W  channel code that produced out_data

## Operation
- Single-entry output register. load_en = ~out_valid | out_ready.
- grant selection (combinational):
  - Directed: grant = sel when in_valid[sel], else none. sel ≥ CHANNELS grants nothing.
  - Round-robin: first valid channel searching from ptr+1 upward, wrapping modulo CHANNELS. No grant if none valid.
- in_ready[grant] = load_en. All other in_ready bits are 0. in_ready never depends on in_valid of other channels' data.
- On load: out_data ← in_data[grant], out_chan ← grant, out_valid ← 1. In round-robin mode, ptr ← grant. In directed mode, ptr is unchanged.
- When out_ready is high and nothing is granted, out_valid ← 0 and out_data/out_chan hold their values.
- ptr persists across mode changes. A mode or sel change takes effect in the same cycle, since it is combinational into grant.
- No data is lost or duplicated. Every accepted input beat appears exactly once on the output, in acceptance order.

## Timing
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1 (so the first round-robin search starts at channel 0), lock=0.
- Reset asserted mid-transfer: the output register is cleared and the held beat is dropped. in_ready is 0 during reset.
- Full, with out_ready low: all in_ready=0 and the output holds steady.
- Simultaneous drain and load: allowed in the same cycle.
- Wrap: with ptr=CHANNELS-1 and all channels valid, channel 0 wins.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - In round-robin mode, once a beat with in_last=0 is accepted from channel g, lock=1 and grant stays on g, even if g deasserts valid, until a beat from g with in_last=1 is accepted.
  - Directed mode ignores and clears lock.
- MUX_ARB_LOCK_EN undefined:
  - in_last is ignored and there is no lock register. Arbitration is per beat.

## Structure
- Package mux_arb_pkg holds:
  - MODE_DIRECT=1'b0 and MODE_RR=1'b1.
  - The default WIDTH/CHANNELS constants.
- Sub-module rr_pick: combinational, parametrised on CHANNELS. Inputs are the valid vector and ptr; outputs are found and the grant index. It is reused by other arbiters.
- Top module contains the output register, ptr, the optional lock register, and the handshake logic.

## Test plan
- Directed mode, CHANNELS=4, sel=2, in_valid=4'b0100, in_data[2]=32'hDEAD_BEEF, out_ready=1:
  - Next cycle out_valid=1, out_data=DEADBEEF, out_chan=2.
  - in_ready=4'b0100 in the accept cycle.
- Round-robin mode, all in_valid=1, out_ready=1 for 6 cycles after reset:
  - out_chan sequence is 0,1,2,3,0,1.
  - in_ready rotates one-hot.
- Backpressure: out_ready=0 with the output full:
  - in_ready=0 and out_data holds for 5 cycles.
  - Raising out_ready loads the next beat in the same cycle as the drain, with no bubble.
- Reset mid-stream: assert reset while out_valid=1.
  - Next cycle out_valid=0 and out_data=0.
  - The first round-robin grant after reset is channel 0.
- MUX_ARB_LOCK_EN, round-robin mode:
  - Channel 1 sends three beats with in_last=0,0,1 while channel 2 is valid throughout.
  - out_chan sequence is 1,1,1,2.
  - Without the macro, the sequence alternates 1,2,1,2.
- Directed mode, sel=3 with in_valid[3]=0 and the others valid:
  - No grant and in_ready=0.
  - out_valid drops after the current beat drains.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants for the N-channel flow-controlled selector.
// Mode codes and default datapath geometry.
package mux_arb_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// Round-robin pick: first valid channel after ptr, wrapping.
// Purely combinational, reusable by any arbiter.
module rr_pick #(
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] valid,
   input  logic [SEL_W-1:0]    ptr,
   output logic                found,
   output logic [SEL_W-1:0]    grant
);

   always_comb begin
      int idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 1; k <= CHANNELS; k++) begin
         idx = (int'(ptr) + k) % CHANNELS;
         if (!found && valid[idx]) begin
            found = 1'b1;
            grant = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel W-bit selector with registered valid/ready output stage.
// Optional burst lock in round-robin mode: define MUX_ARB_LOCK_EN.
module mux_arb_n
   import mux_arb_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS-1:0]       in_last,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_grant;
   logic [SEL_W-1:0] grant;
   logic             rr_found;
   logic             dir_ok;
   logic             grant_ok;
   logic             load_en;
   logic             accept;
   logic             cur_valid;
   logic [WIDTH-1:0] pick_data;

   rr_pick #(
      .CHANNELS(CHANNELS)
   ) u_pick (
      .valid(in_valid),
      .ptr  (ptr),
      .found(rr_found),
      .grant(rr_grant)
   );

   // Out-of-range sel codes match no channel and so grant nothing.
   always_comb begin
      dir_ok = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i)) dir_ok = in_valid[i];
      end
   end

`ifdef MUX_ARB_LOCK_EN
   logic lock;
   logic cur_last;

   always_comb begin
      cur_last = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant == SEL_W'(i)) cur_last = in_last[i];
      end
   end

   // While locked, ptr still names the channel that opened the burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock <= 1'b0;
      end else if (mode == MODE_DIRECT) begin
         lock <= 1'b0;
      end else if (accept) begin
         lock <= ~cur_last;
      end
   end
`else
   logic unused_last;
   assign unused_last = ^in_last;
`endif

   always_comb begin
      grant    = rr_grant;
      grant_ok = rr_found;
      if (mode == MODE_DIRECT) begin
         grant    = sel;
         grant_ok = dir_ok;
      end
`ifdef MUX_ARB_LOCK_EN
      else if (lock) begin
         grant    = ptr;
         grant_ok = 1'b1;
      end
`endif
   end

   always_comb begin
      cur_valid = 1'b0;
      pick_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant == SEL_W'(i)) begin
            cur_valid = in_valid[i];
            pick_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign load_en = ~out_valid | out_ready;
   assign accept  = grant_ok & cur_valid & load_en;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = ~reset & load_en & grant_ok
                     & (grant == SEL_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= SEL_W'(CHANNELS - 1);
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= pick_data;
         out_chan  <= grant;
         if (mode == MODE_RR) ptr <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed-vector bench for mux_arb_n (4 channels, 32 bits).
// Table of per-cycle vectors plus reset and burst-lock sequences.
module tb_mux_arb_n;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'hDEAD_BEEF;
   localparam logic [31:0] D3 = 32'h4444_0003;

   logic        clk;
   logic        reset;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic [127:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_chan;

   int tests;
   int fails;

   mux_arb_n #(
      .WIDTH(32),
      .CHANNELS(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .mode     (mode),
      .sel      (sel),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_chan (out_chan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [1:0]  exp_ch;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] lock_exp[4];
   int beats;

   initial begin
      tests = 0;
      fails = 0;
      in_data   = {D3, D2, D1, D0};
      in_last   = 4'b0000;
      mode      = 1'b1;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      reset     = 1'b1;

      //        mode sel valid   ordy rdy     ov ch data
      vecs[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      vecs[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2, D2};
      vecs[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
      vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
      vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
      vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
      vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
      vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, D1};
      vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      vecs[14] = '{1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
      vecs[15] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      vecs[16] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
      vecs[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, D3};
      vecs[18] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, D3};
      vecs[19] = '{1'b1, 2'd0, 4'b0101, 1'b0, 4'b0001, 1'b1, 2'd0, D0};
      vecs[20] = '{1'b1, 2'd0, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, D0};

`ifdef MUX_ARB_LOCK_EN
      lock_exp[0] = 2'd1; lock_exp[1] = 2'd1;
      lock_exp[2] = 2'd1; lock_exp[3] = 2'd2;
`else
      lock_exp[0] = 2'd1; lock_exp[1] = 2'd2;
      lock_exp[2] = 2'd1; lock_exp[3] = 2'd2;
`endif

      // reset state, with all channels offering data
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_chan", 32'(out_chan), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         mode      = vecs[i].mode;
         sel       = vecs[i].sel;
         in_valid  = vecs[i].valid;
         out_ready = vecs[i].ordy;
         #3;
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready),
             32'(vecs[i].exp_rdy));
         tick();
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid),
             32'(vecs[i].exp_ov));
         chk($sformatf("v%0d_out_chan", i), 32'(out_chan),
             32'(vecs[i].exp_ch));
         chk($sformatf("v%0d_out_data", i), out_data,
             vecs[i].exp_data);
      end

      // burst from channel 1 (last on third beat) vs channel 2
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      mode      = 1'b1;
      out_ready = 1'b1;
      beats     = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = {1'b0, 1'b1, beats < 3, 1'b0};
         in_last  = {2'b00, beats == 2, 1'b0};
         #3;
         if (in_ready[1] && in_valid[1]) beats++;
         tick();
         chk($sformatf("lock_chan%0d", c), 32'(out_chan),
             32'(lock_exp[c]));
      end
      in_last = 4'b0000;

      // reset while the output register is full
      in_valid = 4'b1111;
      tick();
      tick();
      chk("mid_out_valid", 32'(out_valid), 32'h1);
      reset = 1'b1;
      #3;
      chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_out_data", out_data, 32'h0);
      reset = 1'b0;
      #3;
      chk("post_rst_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("post_rst_out_chan", 32'(out_chan), 32'h0);
      chk("post_rst_out_data", out_data, D0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
